// File: rtl/sfr_pkg.sv
// ============================================================================
// Module      : sfr_pkg
// Description : Shared address map, flag indices and interrupt helpers for
//               the special function register file.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sfr_pkg;

    localparam int SFR_ADDR_SREG = 0;
    localparam int SFR_ADDR_IER  = 1;
    localparam int SFR_ADDR_IFR  = 2;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    localparam int NUM_IRQ  = 4;
    localparam int IRQ_ID_W = 2;

    typedef logic [NUM_IRQ-1:0]  irq_vec_t;
    typedef logic [IRQ_ID_W-1:0] irq_id_t;

    // Lowest set index wins; an empty vector encodes to 0.
    function automatic irq_id_t irq_prio_enc(input irq_vec_t v);
        irq_id_t id;
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = irq_id_t'(i);
            end
        end
        return id;
    endfunction

    function automatic irq_vec_t irq_onehot(input irq_id_t id);
        irq_vec_t m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sfr_irq_ctrl.sv
// ============================================================================
// Module      : sfr_irq_ctrl
// Description : Interrupt enable/pending registers with W1C, acknowledge and
//               hardware-set merge, priority encoder and registered request.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sfr_irq_ctrl
    import sfr_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_ier_we,
    input  logic     i_ifr_w1c_we,
    input  irq_vec_t i_wr_bits,
    input  irq_vec_t i_irq_in,
    input  logic     i_irq_ack,
    output irq_vec_t o_ier_q,
    output irq_vec_t o_ier_d,
    output irq_vec_t o_ifr_q,
    output irq_vec_t o_ifr_d,
    output logic     o_irq_req,
    output irq_id_t  o_irq_id
);

    irq_vec_t r_ier;
    irq_vec_t r_ifr;
    logic     r_irq_req;
    irq_id_t  r_irq_id;

    irq_vec_t w_w1c;
    irq_vec_t w_ack_mask;
    irq_vec_t w_ier_d;
    irq_vec_t w_ifr_d;
    irq_vec_t w_active;

    // Acknowledge only clears when a request was actually presented; the
    // hardware set is OR-ed last so a fresh event survives any clear.
    always_comb begin
        w_w1c      = i_ifr_w1c_we ? i_wr_bits : '0;
        w_ack_mask = (i_irq_ack && r_irq_req) ? irq_onehot(r_irq_id) : '0;
        w_ier_d    = i_ier_we ? i_wr_bits : r_ier;
        w_ifr_d    = (r_ifr & ~w_w1c & ~w_ack_mask) | i_irq_in;
        w_active   = w_ifr_d & w_ier_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ier     <= '0;
            r_ifr     <= '0;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            r_ier     <= w_ier_d;
            r_ifr     <= w_ifr_d;
            r_irq_req <= |w_active;
            r_irq_id  <= irq_prio_enc(w_active);
        end
    end

    assign o_ier_q   = r_ier;
    assign o_ier_d   = w_ier_d;
    assign o_ifr_q   = r_ifr;
    assign o_ifr_d   = w_ifr_d;
    assign o_irq_req = r_irq_req;
    assign o_irq_id  = r_irq_id;

endmodule

`default_nettype wire

// File: rtl/sfr_file.sv
// ============================================================================
// Module      : sfr_file
// Description : Memory-stage special function register file with two read
//               ports, SREG flag updates and a 4-line interrupt block.
//               Option SFR_BYPASS_EN: read ports return next-state values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sfr_file
    import sfr_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_SFR = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    input  logic [3:0]        irq_in,
    input  logic              irq_ack,
    output logic              irq_req,
    output logic [1:0]        irq_id
);

    localparam int c_NUM_ADDR = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_cur [c_NUM_ADDR];
    logic [DATA_W-1:0] w_nxt [c_NUM_ADDR];

    irq_vec_t w_ier_q;
    irq_vec_t w_ier_d;
    irq_vec_t w_ifr_q;
    irq_vec_t w_ifr_d;
    logic     w_ier_we;
    logic     w_ifr_we;

    assign w_ier_we = wr_en && (wr_addr == ADDR_W'(SFR_ADDR_IER));
    assign w_ifr_we = wr_en && (wr_addr == ADDR_W'(SFR_ADDR_IFR));

    sfr_irq_ctrl u_irq_ctrl (
        .clk          (clock),
        .rst_n        (reset_n),
        .i_ier_we     (w_ier_we),
        .i_ifr_w1c_we (w_ifr_we),
        .i_wr_bits    (wr_data[NUM_IRQ-1:0]),
        .i_irq_in     (irq_in),
        .i_irq_ack    (irq_ack),
        .o_ier_q      (w_ier_q),
        .o_ier_d      (w_ier_d),
        .o_ifr_q      (w_ifr_q),
        .o_ifr_d      (w_ifr_d),
        .o_irq_req    (irq_req),
        .o_irq_id     (irq_id)
    );

    // Every address gets a current and next view; unmapped slots read 0 so
    // the read muxes stay full-width with no range check.
    generate
        for (genvar i = 0; i < c_NUM_ADDR; i++) begin : g_sfr
            if (i >= NUM_SFR) begin : g_absent
                assign w_cur[i] = '0;
                assign w_nxt[i] = '0;
            end else if (i == SFR_ADDR_IER) begin : g_ier
                assign w_cur[i] = {{(DATA_W-NUM_IRQ){1'b0}}, w_ier_q};
                assign w_nxt[i] = {{(DATA_W-NUM_IRQ){1'b0}}, w_ier_d};
            end else if (i == SFR_ADDR_IFR) begin : g_ifr
                assign w_cur[i] = {{(DATA_W-NUM_IRQ){1'b0}}, w_ifr_q};
                assign w_nxt[i] = {{(DATA_W-NUM_IRQ){1'b0}}, w_ifr_d};
            end else begin : g_reg
                logic              w_we;
                logic [DATA_W-1:0] r_q;

                assign w_we = wr_en && (wr_addr == ADDR_W'(i));

                if (i == SFR_ADDR_SREG) begin : g_sreg
                    // Explicit write overrides the ALU flag update on all bits.
                    assign w_nxt[i] = w_we    ? wr_data :
                                      flag_we ? {r_q[DATA_W-1:NUM_FLAGS], flag_in} :
                                                r_q;
                end else begin : g_plain
                    assign w_nxt[i] = w_we ? wr_data : r_q;
                end

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_nxt[i];
                    end
                end

                assign w_cur[i] = r_q;
            end
        end
    endgenerate

`ifdef SFR_BYPASS_EN
    assign rd_data_a = w_nxt[rd_addr_a];
    assign rd_data_b = w_nxt[rd_addr_b];
`else
    // Stored values only: decode must stall one cycle on SFR read-after-write.
    assign rd_data_a = w_cur[rd_addr_a];
    assign rd_data_b = w_cur[rd_addr_b];
`endif

endmodule

`default_nettype wire

// File: tb/tb_sfr_file.sv
// ============================================================================
// Module      : tb_sfr_file
// Description : Self-checking bench for sfr_file (NUM_SFR=12 build).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sfr_file;

    localparam int DATA_W  = 8;
    localparam int NUM_SFR = 12;
    localparam int ADDR_W  = 4;
    localparam int NVEC    = 26;
`ifdef SFR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              flag_we;
    logic [3:0]        flag_in;
    logic [3:0]        irq_in;
    logic              irq_ack;
    logic              irq_req;
    logic [1:0]        irq_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    sfr_file #(
        .DATA_W  (DATA_W),
        .NUM_SFR (NUM_SFR),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .irq_in    (irq_in),
        .irq_ack   (irq_ack),
        .irq_req   (irq_req),
        .irq_id    (irq_id)
    );

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       fwe;
        logic [3:0] fin;
        logic [3:0] irq;
        logic       ack;
        logic [3:0] ra;
        logic [7:0] ea;
        logic [3:0] rb;
        logic [7:0] eb;
        logic       req;
        logic [1:0] id;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       req;
        logic [1:0] id;
    } exp_t;

    vec_t tbl [NVEC];
    exp_t sb [$];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                input logic fwe, input logic [3:0] fin, input logic [3:0] irq,
                                input logic ack, input logic [3:0] ra, input logic [7:0] ea,
                                input logic [3:0] rb, input logic [7:0] eb,
                                input logic req, input logic [1:0] id);
        vec_t v;
        v.we = we;   v.wa = wa;   v.wd = wd;  v.fwe = fwe; v.fin = fin;
        v.irq = irq; v.ack = ack; v.ra = ra;  v.ea = ea;   v.rb = rb;
        v.eb = eb;   v.req = req; v.id = id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        flag_we = 1'b0; flag_in = '0; irq_in = '0; irq_ack = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
    endtask

    // Drive one row, queue its expectations, then sample before the edge.
    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        wr_en = t.we; wr_addr = t.wa; wr_data = t.wd;
        flag_we = t.fwe; flag_in = t.fin; irq_in = t.irq; irq_ack = t.ack;
        rd_addr_a = t.ra; rd_addr_b = t.rb;
        e.idx = idx; e.a = t.ea; e.b = t.eb; e.req = t.req; e.id = t.id;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d rd_a", e.idx), rd_data_a, e.a);
            chk($sformatf("row%0d rd_b", e.idx), rd_data_b, e.b);
            chk($sformatf("row%0d irq_req", e.idx), {7'd0, irq_req}, {7'd0, e.req});
            chk($sformatf("row%0d irq_id", e.idx), {6'd0, irq_id}, {6'd0, e.id});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset_n   = 1'b0;
        rd_addr_a = 4'd5;
        #3;
        chk("reset rd_a", rd_data_a, 8'h00);
        chk("reset rd_b", rd_data_b, 8'h00);
        chk("reset irq_req", {7'd0, irq_req}, 8'h00);
        chk("reset irq_id", {6'd0, irq_id}, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        //           we wa    wd     fwe fin    irq    ack ra     ea     rb     eb     req id
        tbl[0]  = mk(1, 4'd5, 8'hA5, 0, 4'h0, 4'h0, 0, 4'd3, 8'h00, 4'd0, 8'h00, 0, 2'd0);
        tbl[1]  = mk(1, 4'd7, 8'h3C, 0, 4'h0, 4'h0, 0, 4'd5, 8'hA5, 4'd11, 8'h00, 0, 2'd0);
        tbl[2]  = mk(1, 4'd0, 8'hF0, 1, 4'h5, 4'h0, 0, 4'd7, 8'h3C, 4'd15, 8'h00, 0, 2'd0);
        tbl[3]  = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd0, 8'hF0, 4'd7, 8'h3C, 0, 2'd0);
        tbl[4]  = mk(0, 4'd0, 8'h00, 1, 4'h3, 4'h0, 0, 4'd1, 8'h00, 4'd5, 8'hA5, 0, 2'd0);
        tbl[5]  = mk(1, 4'd1, 8'hFF, 0, 4'h0, 4'h0, 0, 4'd0, 8'hF3, 4'd5, 8'hA5, 0, 2'd0);
        tbl[6]  = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'hA, 0, 4'd1, 8'h0F, 4'd0, 8'hF3, 0, 2'd0);
        tbl[7]  = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h0A, 4'd0, 8'hF3, 1, 2'd1);
        tbl[8]  = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 1, 4'd1, 8'h0F, 4'd0, 8'hF3, 1, 2'd1);
        tbl[9]  = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h08, 4'd1, 8'h0F, 1, 2'd3);
        tbl[10] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 1, 4'd5, 8'hA5, 4'd7, 8'h3C, 1, 2'd3);
        tbl[11] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h1, 0, 4'd5, 8'hA5, 4'd0, 8'hF3, 0, 2'd0);
        tbl[12] = mk(1, 4'd2, 8'h01, 0, 4'h0, 4'h1, 0, 4'd7, 8'h3C, 4'd0, 8'hF3, 1, 2'd0);
        tbl[13] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h01, 4'd1, 8'h0F, 1, 2'd0);
        tbl[14] = mk(1, 4'd2, 8'h01, 0, 4'h0, 4'h0, 0, 4'd0, 8'hF3, 4'd5, 8'hA5, 1, 2'd0);
        tbl[15] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h00, 4'd1, 8'h0F, 0, 2'd0);
        tbl[16] = mk(1, 4'd1, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h00, 4'd0, 8'hF3, 0, 2'd0);
        tbl[17] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'hF, 0, 4'd1, 8'h00, 4'd5, 8'hA5, 0, 2'd0);
        tbl[18] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h0F, 4'd1, 8'h00, 0, 2'd0);
        tbl[19] = mk(1, 4'd1, 8'h04, 0, 4'h0, 4'h0, 0, 4'd2, 8'h0F, 4'd0, 8'hF3, 0, 2'd0);
        tbl[20] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd1, 8'h04, 4'd2, 8'h0F, 1, 2'd2);
        tbl[21] = mk(1, 4'd15, 8'h77, 0, 4'h0, 4'h0, 0, 4'd2, 8'h0F, 4'd11, 8'h00, 1, 2'd2);
        tbl[22] = mk(1, 4'd11, 8'h5A, 0, 4'h0, 4'h0, 0, 4'd15, 8'h00, 4'd3, 8'h00, 1, 2'd2);
        tbl[23] = mk(1, 4'd1, 8'h00, 0, 4'h0, 4'h0, 0, 4'd11, 8'h5A, 4'd15, 8'h00, 1, 2'd2);
        tbl[24] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 1, 4'd0, 8'hF3, 4'd1, 8'h00, 0, 2'd0);
        tbl[25] = mk(0, 4'd0, 8'h00, 0, 4'h0, 4'h0, 0, 4'd2, 8'h0F, 4'd1, 8'h00, 0, 2'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            apply(tbl[i], i);
        end

        // Same-cycle write visibility on a plain register.
        @(negedge clock);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C; rd_addr_a = 4'd9;
        #2;
        chk("bypass_wr same cycle", rd_data_a, BYP ? 8'h3C : 8'h00);
        @(negedge clock);
        idle_inputs();
        rd_addr_a = 4'd9;
        #2;
        chk("bypass_wr next cycle", rd_data_a, 8'h3C);

        // Same-cycle W1C visibility on IFR.
        @(negedge clock);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h0F; rd_addr_a = 4'd2;
        #2;
        chk("bypass_w1c same cycle", rd_data_a, BYP ? 8'h00 : 8'h0F);
        @(negedge clock);
        idle_inputs();
        rd_addr_a = 4'd2;
        #2;
        chk("bypass_w1c next cycle", rd_data_a, 8'h00);

        // Asynchronous reset mid-operation, with an active request.
        @(negedge clock);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h01; irq_in = 4'h1;
        @(negedge clock);
        idle_inputs();
        rd_addr_a = 4'd5; rd_addr_b = 4'd0;
        #2;
        chk("pre_reset irq_req", {7'd0, irq_req}, 8'h01);
        chk("pre_reset rd_a", rd_data_a, 8'hA5);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset rd_a", rd_data_a, 8'h00);
        chk("async_reset rd_b", rd_data_b, 8'h00);
        chk("async_reset irq_req", {7'd0, irq_req}, 8'h00);
        chk("async_reset irq_id", {6'd0, irq_id}, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
